collision_detector: RTL and testbench

Parametrised collision buffer with built-in overlap detection. It is the next generation of the 1Kx9 collision buffer. During sprite rendering, the sprite engine streams (pixel address, sprite ID) pairs into the block. The block performs a pipelined read-modify-write per pixel, and whenever a pixel lands on a location already owned by a different sprite it queues the colliding ID pair in a FIFO for the host. A hardware clear sweep empties the buffer between frames.

---
 rtl/collision_detector_pkg.sv | 23 ++
 rtl/collision_detector_ram.sv | 26 ++
 rtl/collision_detector.sv | 141 ++++++++++++++
 tb/tb_collision_detector.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_detector_pkg.sv
// Shared definitions for the collision detector: parameter defaults, the RAM word
// layout and the clear state machine encoding.
package collision_detector_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    // A RAM word is {valid, id}; the valid flag sits directly above the ID field.
    typedef struct packed {
        logic                    valid;
        logic [DEF_ID_WIDTH-1:0] id;
    } word_t;

    function automatic int valid_pos(input int id_width);
        return id_width;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

endpackage

// File: rtl/collision_detector_ram.sv
// Simple dual-port RAM: one write port, one read port with 1-cycle latency.
// A read and a write to the same address in one cycle return the old contents.
module collision_ram
    import collision_detector_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_ID_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/collision_detector.sv
// Collision buffer: pipelined read-modify-write of sprite ownership per pixel,
// a FIFO of colliding ID pairs for the host, and a hardware clear sweep.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic [ID_WIDTH-1:0]   pix_id,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  coll_valid,
    output logic [ID_WIDTH-1:0]   coll_id_a,
    output logic [ID_WIDTH-1:0]   coll_id_b,
    input  logic                  coll_pop,
    output logic                  coll_overflow
);

    localparam int WORD_W    = ID_WIDTH + 1;
    localparam int VALID_BIT = valid_pos(ID_WIDTH);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   sweep_cnt;
    logic                  pix_go, clear_go;

    logic                  vld_p1, fwd_hit_p1, swp_we_p1;
    logic [ADDR_WIDTH-1:0] addr_p1, swp_addr_p1;
    logic [ID_WIDTH-1:0]   id_p1;
    logic [WORD_W-1:0]     fwd_word_p1;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [WORD_W-1:0]     ram_wdata, ram_rdata, old_word;
    logic                  collide, push, pop, full;

    logic [ID_WIDTH-1:0]   fifo_a [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_b [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [PTR_W:0]        count;

    assign clear_busy = (state != ST_IDLE);
    assign pix_ready  = !clear_busy;
    assign pix_go     = pix_valid && pix_ready;
    assign clear_go   = clear_start && (state == ST_IDLE);

    // Sweep writes are registered one cycle behind the counter, so SWEEP lingers
    // one extra cycle while the write of the last address retires.
    always_comb begin
        ram_we    = vld_p1;
        ram_waddr = addr_p1;
        ram_wdata = {1'b1, id_p1};
        if (swp_we_p1) begin
            ram_we    = 1'b1;
            ram_waddr = swp_addr_p1;
            ram_wdata = '0;
        end
    end

    collision_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pix_addr),
        .rdata (ram_rdata)
    );

    // Stage 2: the RAM returns pre-write data, so a write landing on the word
    // being read in the same cycle is forwarded instead.
    assign old_word = fwd_hit_p1 ? fwd_word_p1 : ram_rdata;
    assign collide  = vld_p1 && old_word[VALID_BIT] && (old_word[ID_WIDTH-1:0] != id_p1);

    assign coll_valid = (count != '0);
    assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = coll_pop && coll_valid;
    assign push       = collide && (!full || pop);
    assign coll_id_a  = coll_valid ? fifo_a[rd_ptr] : '0;
    assign coll_id_b  = coll_valid ? fifo_b[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_DRAIN;
            sweep_cnt     <= '0;
            swp_we_p1     <= 1'b0;
            vld_p1        <= 1'b0;
            fwd_hit_p1    <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            coll_overflow <= 1'b0;
        end else begin
            vld_p1     <= pix_go;
            fwd_hit_p1 <= pix_go && ram_we && (ram_waddr == pix_addr);
            swp_we_p1  <= (state == ST_SWEEP) && !sweep_cnt[ADDR_WIDTH];
            case (state)
                ST_IDLE:  if (clear_go) state <= ST_DRAIN;
                ST_DRAIN: begin
                    state     <= ST_SWEEP;
                    sweep_cnt <= '0;
                end
                ST_SWEEP: begin
                    if (sweep_cnt[ADDR_WIDTH]) begin
                        state     <= ST_IDLE;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + (ADDR_WIDTH+1)'(1);
                    end
                end
                default:  state <= ST_IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (collide && full && !pop) coll_overflow <= 1'b1;
            else if (clear_go)           coll_overflow <= 1'b0;
        end
    end

    // Stage 1 data capture and FIFO storage carry no reset; validity is tracked above.
    always_ff @(posedge clk) begin
        addr_p1     <= pix_addr;
        id_p1       <= pix_id;
        fwd_word_p1 <= ram_wdata;
        swp_addr_p1 <= sweep_cnt[ADDR_WIDTH-1:0];
        if (push) begin
            fifo_a[wr_ptr] <= old_word[ID_WIDTH-1:0];
            fifo_b[wr_ptr] <= id_p1;
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: an ownership-map model predicts the
// collision pairs, and an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_collision_detector;

    localparam int AW = 10;
    localparam int IW = 8;
    localparam int FD = 16;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid, pix_ready;
    logic [AW-1:0] pix_addr;
    logic [IW-1:0] pix_id;
    logic          clear_start, clear_busy;
    logic          coll_valid, coll_pop, coll_overflow;
    logic [IW-1:0] coll_id_a, coll_id_b;
    logic          mon_pop, man_pop;

    typedef struct {
        int a;
        int b;
    } pair_t;

    pair_t exp_q[$];
    bit    model_vld[N];
    int    model_id[N];
    bit    exp_ovf;
    bit    mon_en;
    int    pop_pct;
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;
    assign coll_pop = mon_pop | man_pop;

    collision_detector #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_addr      (pix_addr),
        .pix_id        (pix_id),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .coll_valid    (coll_valid),
        .coll_id_a     (coll_id_a),
        .coll_id_b     (coll_id_b),
        .coll_pop      (coll_pop),
        .coll_overflow (coll_overflow)
    );

    function automatic void check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Reference: the buffer is an ownership map; the FIFO is a bounded queue.
    function automatic void model_pixel(input int a, input int id);
        if (model_vld[a] && model_id[a] != id) begin
            if (exp_q.size() < FD) exp_q.push_back('{model_id[a], id});
            else exp_ovf = 1'b1;
        end
        model_vld[a] = 1'b1;
        model_id[a]  = id;
    endfunction

    function automatic void model_wipe();
        foreach (model_vld[i]) model_vld[i] = 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pixel(input int a, input int id, input bit with_clear);
        check("pix_ready_at_issue", pix_ready, 1);
        pix_valid   = 1'b1;
        pix_addr    = a[AW-1:0];
        pix_id      = id[IW-1:0];
        clear_start = with_clear;
        model_pixel(a, id);
        if (with_clear) begin
            model_wipe();
            exp_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic count_busy(output int n, input int poke);
        n = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (!clear_busy) break;
            clear_start = (i == poke);
            n++;
            @(posedge clk);
            #1;
        end
        clear_start = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || coll_valid) && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_coll_valid"}, coll_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_clear_busy"}, clear_busy, 1);
        check({tag, "_coll_valid"}, coll_valid, 0);
        check({tag, "_coll_id_a"}, coll_id_a, 0);
        check({tag, "_coll_id_b"}, coll_id_b, 0);
        check({tag, "_coll_overflow"}, coll_overflow, 0);
    endtask

    task automatic random_phase(input int cycles, input bit wide);
        int a;
        for (int c = 0; c < cycles; c++) begin
            if (exp_q.size() <= 10 && $urandom_range(1) == 1) begin
                a = (wide && $urandom_range(1) == 1) ? 1000 + $urandom_range(23) : $urandom_range(31);
                pixel(a, $urandom_range(3), 1'b0);
            end else begin
                idle(1);
            end
        end
    endtask

    // Monitor: pops the head whenever one is presented and compares it in order.
    initial begin
        pair_t p;
        mon_pop = 1'b0;
        forever begin
            @(negedge clk);
            mon_pop = 1'b0;
            if (mon_en && coll_valid && $urandom_range(99) < pop_pct) begin
                check("expected_pair_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    check("coll_id_a", coll_id_a, p.a);
                    check("coll_id_b", coll_id_b, p.b);
                end
                mon_pop = 1'b1;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_id = '0;
        clear_start = 1'b0; man_pop = 1'b0; mon_en = 1'b0; pop_pct = 100; exp_ovf = 1'b0;
        idle(3);
        check_reset_values("reset");

        reset = 1'b0;
        model_wipe();
        count_busy(n, -1);
        check("reset_sweep_busy_cycles", n, N + 2);
        check("ready_after_reset_sweep", pix_ready, 1);

        // Single overlap with explicit push latency
        mon_en = 1'b1;
        pixel(5, 3, 1'b0);
        idle(4);
        pixel(5, 7, 1'b0);
        check("overlap_valid_t1", coll_valid, 0);
        idle(1);
        check("overlap_valid_t2", coll_valid, 1);
        idle(1);
        check("overlap_popped", coll_valid, 0);

        // Back-to-back same address relies on forwarding
        pixel(9, 1, 1'b0);
        pixel(9, 2, 1'b0);
        pixel(9, 2, 1'b0);
        drain("forward");

        pop_pct = 75;
        random_phase(800, 1'b0);
        drain("random1");

        // Overflow: 17 collisions with no pops, then a push that coincides with a pop
        mon_en = 1'b0;
        idle(2);
        for (int k = 0; k < 17; k++) begin
            pixel(100 + k, k + 1, 1'b0);
            pixel(100 + k, k + 40, 1'b0);
        end
        idle(3);
        check("overflow_set", coll_overflow, exp_ovf);
        check("full_head_a", coll_id_a, exp_q[0].a);
        check("full_head_b", coll_id_b, exp_q[0].b);
        check("pix_ready_full", pix_ready, 1);
        pix_valid = 1'b1; pix_addr = AW'(100); pix_id = IW'(77);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        man_pop   = 1'b1;
        check("popfull_head_a", coll_id_a, exp_q[0].a);
        check("popfull_head_b", coll_id_b, exp_q[0].b);
        void'(exp_q.pop_front());
        model_pixel(100, 77);
        @(posedge clk);
        #1;
        man_pop = 1'b0;
        idle(2);
        check("overflow_sticky", coll_overflow, exp_ovf);
        mon_en = 1'b1; pop_pct = 50;
        drain("overflow");

        // Clear: pixel accepted alongside clear_start, second clear ignored, FIFO kept
        mon_en = 1'b0;
        idle(2);
        pixel(30, 1, 1'b0);
        pixel(30, 2, 1'b0);
        idle(3);
        pixel(20, 5, 1'b1);
        check("ready_low_after_clear", pix_ready, 0);
        count_busy(n, 100);
        check("clear_busy_cycles", n, N + 2);
        check("ready_after_clear", pix_ready, 1);
        check("overflow_cleared", coll_overflow, exp_ovf);
        check("fifo_kept", coll_valid, exp_q.size() > 0);
        mon_en = 1'b1;
        pixel(20, 9, 1'b0);
        drain("clear");

        // Reset in the middle of a sweep restarts the sweep from address 0
        mon_en = 1'b0;
        idle(2);
        pixel(40, 1, 1'b0);
        pixel(40, 2, 1'b0);
        idle(3);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        model_wipe();
        exp_ovf = 1'b0;
        idle(301);
        reset = 1'b1;
        #1;
        check_reset_values("midsweep");
        exp_q.delete();
        model_wipe();
        idle(2);
        reset = 1'b0;
        count_busy(n, -1);
        check("midsweep_restart_busy_cycles", n, N + 2);
        check("ready_after_restart", pix_ready, 1);

        mon_en = 1'b1; pop_pct = 75;
        random_phase(800, 1'b1);
        drain("random2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
